// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_sequencer
//  Description : Control-step sequencer and PC register for the conditional
//                branch instructions (brzr/brnz/brpl/brmi). Strobes the CON
//                flip-flop, then uses its latched result to decide whether
//                the computed branch target is written into PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_sequencer #(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic [BITS-1:0] bus_in,
  input  logic            start,
  input  logic            pc_inc,
  input  logic            stall,
  input  logic            con,
  output logic            gra,
  output logic            r_out,
  output logic            con_enable,
  output logic            pc_out,
  output logic            y_in,
  output logic            c_out,
  output logic            add_op,
  output logic            z_in,
  output logic            z_lo_out,
  output logic            pc_in,
  output logic [BITS-1:0] pc,
  output logic            busy,
  output logic            done,
  output logic            taken
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RA0  = 3'd1,
    S_RA1  = 3'd2,
    S_PC   = 3'd3,
    S_OFF  = 3'd4,
    S_WB   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  // CON is latched in the second T_RA cycle and is stable long before T_WB,
  // so a one-cycle registered copy carries the same value into T_WB while
  // keeping pc_in free of any combinational path from an input.
  logic   con_q;

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and strobe decode; strobes depend on registered state only.
  always_comb begin
    state_next = state;
    gra        = 1'b0;
    r_out      = 1'b0;
    con_enable = 1'b0;
    pc_out     = 1'b0;
    y_in       = 1'b0;
    c_out      = 1'b0;
    add_op     = 1'b0;
    z_in       = 1'b0;
    z_lo_out   = 1'b0;
    pc_in      = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RA0;
      end
      S_RA0: begin
        gra   = 1'b1;
        r_out = 1'b1;
        if (!stall) state_next = S_RA1;
      end
      S_RA1: begin
        // Held high across a stall so the CON flip-flop sees a single edge.
        gra        = 1'b1;
        r_out      = 1'b1;
        con_enable = 1'b1;
        if (!stall) state_next = S_PC;
      end
      S_PC: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
        if (!stall) state_next = S_OFF;
      end
      S_OFF: begin
        c_out  = 1'b1;
        add_op = 1'b1;
        z_in   = 1'b1;
        if (!stall) state_next = S_WB;
      end
      S_WB: begin
        z_lo_out = 1'b1;
        pc_in    = con_q;
        if (!stall) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!stall) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // PC, branch result and CON sample; PC/taken only change in IDLE or on the
  // unstalled edge leaving T_WB.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pc    <= RESET_PC;
      taken <= 1'b0;
      con_q <= 1'b0;
    end else begin
      con_q <= con;
      if (state == S_IDLE) begin
        if (pc_inc) pc <= pc + BITS'(1);
        if (start)  taken <= 1'b0;
      end else if (state == S_WB && !stall) begin
        if (con_q) pc <= bus_in;
        taken <= con_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/branch_sequencer.md
# branch_sequencer

Control-step sequencer and program-counter register for the conditional-branch instructions (brzr/brnz/brpl/brmi). Sits directly downstream of the CON flip-flop: it produces the `con_enable` strobe that makes the CON flip-flop latch its condition from the bus, then consumes the latched `con` result to decide whether the computed branch target is written into PC. It owns the PC register and drives the bus-control strobes for the branch micro-sequence.

## Interface
- `BITS`, 32: datapath and PC width.
- `RESET_PC`, 0: PC value loaded on reset.

- `clock`  in  1  system clock, rising-edge active.
- `clear_n`  in  1  asynchronous, active-low reset.
- `bus_in`  in  BITS  current bus contents.
- `start`  in  1  branch instruction decoded; accepted only in IDLE.
- `pc_inc`  in  1  fetch increment; PC <= PC+1, honoured only in IDLE.
- `stall`  in  1  hold current step (memory/bus wait).
- `con`  in  1  Q output of the CON flip-flop.
- `gra`, `r_out`  out  1  select Ra field, drive register onto bus.
- `con_enable`  out  1  CON flip-flop latch strobe (its rising edge is the latch event).
- `pc_out`, `y_in`  out  1  drive PC onto bus; load Y.
- `c_out`, `add_op`, `z_in`  out  1  drive sign-extended C; ALU add; load Z.
- `z_lo_out`  out  1  drive Z-low onto bus.
- `pc_in`  out  1  PC load from bus this cycle (asserted only when the branch is taken).
- `pc`  out  BITS  program counter.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `taken`  out  1  result of the last branch; held until the next accepted `start`.

## Operation
- States: IDLE, T_RA (2 sub-cycles), T_PC, T_OFF, T_WB, T_DONE.
- All strobes are decoded from the registered state only. No combinational path from any input to any output.
- IDLE: all strobes 0. `start`=1 moves to T_RA sub-cycle 0 and clears `taken`. `pc_inc`=1 increments PC. If both are high, both act in the same cycle.
- T_RA sub-cycle 0: `gra`, `r_out`=1. Sub-cycle 1: `gra`, `r_out`, `con_enable`=1. The bus is already stable a full cycle before the `con_enable` rising edge.
- T_PC: `pc_out`, `y_in`=1.
- T_OFF: `c_out`, `add_op`, `z_in`=1.
- T_WB: `z_lo_out`=1. `pc_in`=`con`. On the exiting edge, if `con`=1 then PC <= `bus_in`, and `taken` <= `con`.
- T_DONE: `done`=1 for one cycle, then IDLE.
- `stall`=1 in any non-IDLE state:
  - state, sub-cycle and strobes hold.
  - `con_enable` stays high if stalled in sub-cycle 1 (no second rising edge).
  - No PC or `taken` write occurs until the T_WB cycle in which `stall`=0.
- `start` and `pc_inc` are ignored while `busy`=1.
- PC arithmetic is modulo 2^BITS: `pc_inc` at all-ones wraps to 0.
- Reset (`clear_n`=0, any time, asynchronous):
  - state IDLE, `pc`=RESET_PC.
  - `taken`, `done`, `busy` and all strobes = 0.
  - A reset mid-sequence aborts the branch with no PC write.

## Timing
- `start` sampled high at edge k: T_RA occupies cycles k+1 and k+2, T_PC k+3, T_OFF k+4, T_WB k+5, T_DONE k+6.
- Next `start` is accepted at the edge ending cycle k+7.
- Each stalled cycle adds exactly one cycle of latency at the stalled step.
- New PC is visible on `pc` in the T_DONE cycle (k+6 with no stall).
- `con` must be valid by the T_WB cycle. The CON flip-flop latches at the `con_enable` rising edge in cycle k+2, giving three cycles of margin.
- `pc_inc` result is visible one cycle after the sampling edge.

## Test plan
- Reset: assert `clear_n`=0 mid-T_OFF -> `pc`=0 immediately, all strobes 0, `busy`=0; after release, IDLE with no PC write.
- Taken branch: PC=0x10, `start` at edge k, `con`=1, `bus_in`=0x40 in T_WB -> `pc_in`=1 in cycle k+5, `pc`=0x40 and `done`=1 in k+6, `taken`=1.
- Not-taken branch: same stimulus with `con`=0 -> `pc_in` never asserted, `pc` stays 0x10, `done` in k+6, `taken`=0.
- Stall: `stall`=1 for 3 cycles during T_RA sub-cycle 1 -> `con_enable` shows a single rising edge and stays high 4 cycles, `done` in k+9.
- Simultaneous `start` and `pc_inc` at PC=0xFFFFFFFF -> PC wraps to 0 and the sequence starts. `start`/`pc_inc` pulsed while `busy` -> no effect on PC or state.
- Back-to-back: second `start` held high from k+1 -> accepted only at the edge ending k+7, second `done` at k+13.
